// File: rtl/idex_skid_stage.sv
// idex_skid_stage: ID/EX valid/ready stage with a 2-entry skid buffer.
// Define IDEX_PERF_EN to add saturating stall/flush performance counters.
module idex_skid_stage #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic [XLEN-1:0]   in_op1,
  input  logic [XLEN-1:0]   in_op2,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_pred,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc4,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_pred,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   haz_rd,
  output logic              haz_mem_read,
  output logic              haz_reg_write,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [RD_W-1:0]   rd;
    logic              pred;
    logic              reg_write;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
  } pl_t;

  pl_t  in_pl;
  pl_t  main_pl;
  pl_t  skid_pl;
  logic main_valid;
  logic skid_valid;
  logic acc;
  logic drain;

  assign in_pl = '{
    pc4:       in_pc4,
    op1:       in_op1,
    op2:       in_op2,
    rd:        in_rd,
    pred:      in_pred,
    reg_write: in_reg_write,
    mem_read:  in_mem_read,
    ctrl:      in_ctrl
  };

  // in_ready comes straight from a flop: no EX->ID comb path
  assign in_ready = ~skid_valid;
  assign acc      = in_valid & in_ready;
  assign drain    = ~main_valid | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pl    <= '0;
      skid_pl    <= '0;
    end else begin
      unique case (1'b1)
        flush: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
        (!flush && drain): begin
          if (skid_valid) begin
            main_pl    <= skid_pl;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
          end else begin
            main_valid <= acc;
            if (acc) main_pl <= in_pl;
          end
        end
        (!flush && !drain): begin
          if (acc) begin
            skid_pl    <= in_pl;
            skid_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = main_valid;
  assign out_pc4       = main_pl.pc4;
  assign out_op1       = main_pl.op1;
  assign out_op2       = main_pl.op2;
  assign out_rd        = main_pl.rd;
  assign out_pred      = main_pl.pred;
  assign out_reg_write = main_pl.reg_write;
  assign out_mem_read  = main_pl.mem_read;
  assign out_ctrl      = main_pl.ctrl;

  assign haz_rd        = main_valid ? main_pl.rd : '0;
  assign haz_mem_read  = main_valid & main_pl.mem_read;
  assign haz_reg_write = main_valid & main_pl.reg_write;

`ifdef IDEX_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_valid && !out_ready && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (flush && (main_valid || skid_valid) && flush_q != 32'hFFFF_FFFF)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_idex_skid_stage.sv
// tb_idex_skid_stage: scoreboard bench for idex_skid_stage.
// Reference is a 2-deep FIFO queue; checks payload, handshake, hazards, perf.
module tb_idex_skid_stage;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        pred;
    logic        rw;
    logic        mr;
    logic [11:0] ctrl;
  } pl_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc4, out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_pred, out_reg_write, out_mem_read;
  logic [11:0] out_ctrl;
  logic [4:0]  haz_rd;
  logic        haz_mem_read, haz_reg_write;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  pl_t         drv;

  pl_t         q[$];
  int unsigned m_stall;
  int unsigned m_flush;
  int          n_cmp;
  int          n_bad;

  idex_skid_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc4         (drv.pc4),
    .in_op1         (drv.op1),
    .in_op2         (drv.op2),
    .in_rd          (drv.rd),
    .in_pred        (drv.pred),
    .in_reg_write   (drv.rw),
    .in_mem_read    (drv.mr),
    .in_ctrl        (drv.ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc4        (out_pc4),
    .out_op1        (out_op1),
    .out_op2        (out_op2),
    .out_rd         (out_rd),
    .out_pred       (out_pred),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_ctrl       (out_ctrl),
    .haz_rd         (haz_rd),
    .haz_mem_read   (haz_mem_read),
    .haz_reg_write  (haz_reg_write),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: queue of accepted entries, capacity 2, ready = room left
  always @(posedge clk) begin
    int n;
    if (!rst) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      n = q.size();
      if (n > 0 && !out_ready) m_stall++;
      if (flush) begin
        if (n > 0) m_flush++;
        q.delete();
      end else begin
        if (n > 0 && out_ready) void'(q.pop_front());
        if (in_valid && n < 2) q.push_back(drv);
      end
    end
  end

  always @(negedge clk) begin
    pl_t e;
    if (rst) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        e = q[0];
        chk("out_pc4", out_pc4, e.pc4);
        chk("out_op1", out_op1, e.op1);
        chk("out_op2", out_op2, e.op2);
        chk("out_rd", out_rd, e.rd);
        chk("out_pred", out_pred, e.pred);
        chk("out_reg_write", out_reg_write, e.rw);
        chk("out_mem_read", out_mem_read, e.mr);
        chk("out_ctrl", out_ctrl, e.ctrl);
        chk("haz_rd", haz_rd, e.rd);
        chk("haz_mem_read", haz_mem_read, e.mr);
        chk("haz_reg_write", haz_reg_write, e.rw);
      end else begin
        chk("haz_rd_idle", haz_rd, 0);
        chk("haz_mem_read_idle", haz_mem_read, 0);
        chk("haz_reg_write_idle", haz_reg_write, 0);
      end
`ifdef IDEX_PERF_EN
      chk("perf_stall_cnt", perf_stall_cnt, m_stall);
      chk("perf_flush_cnt", perf_flush_cnt, m_flush);
`else
      chk("perf_stall_cnt", perf_stall_cnt, 0);
      chk("perf_flush_cnt", perf_flush_cnt, 0);
`endif
    end
  end

  function automatic pl_t mk(input logic [4:0] rd);
    pl_t p;
    p.pc4  = $urandom;
    p.op1  = $urandom;
    p.op2  = $urandom;
    p.rd   = rd;
    p.pred = 1'($urandom_range(0, 1));
    p.rw   = 1'($urandom_range(0, 1));
    p.mr   = 1'($urandom_range(0, 1));
    p.ctrl = 12'($urandom);
    return p;
  endfunction

  // Called at a negedge; returns whether the entry was accepted
  task automatic cyc(input logic v, input pl_t p, input logic ordy,
                     input logic fl, output logic acc);
    logic rdy;
    in_valid  = v;
    drv       = p;
    out_ready = ordy;
    flush     = fl;
    rdy       = in_ready;
    @(negedge clk);
    acc = v & rdy & ~fl;
  endtask

  initial begin
    pl_t  p;
    logic a;
    logic done;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drv       = mk(5'd0);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc4", out_pc4, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    p = mk(5'd3);
    p.pc4 = 32'h104;
    p.op1 = 32'd5;
    p.op2 = 32'd7;
    cyc(1'b1, p, 1'b1, 1'b0, a);
    cyc(1'b0, p, 1'b1, 1'b0, a);

    for (int i = 1; i <= 4; i++) cyc(1'b1, mk(5'(i)), 1'b1, 1'b0, a);
    repeat (2) cyc(1'b0, p, 1'b1, 1'b0, a);

    cyc(1'b1, mk(5'd1), 1'b0, 1'b0, a);
    cyc(1'b1, mk(5'd2), 1'b0, 1'b0, a);
    p = mk(5'd3);
    cyc(1'b1, p, 1'b0, 1'b0, a);
    cyc(1'b1, p, 1'b0, 1'b0, a);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc(1'b1, p, 1'b1, 1'b0, a);
      done = a;
    end
    if (!done) begin
      n_bad++;
      $display("FAIL stall_accept_timeout: rd=3 never accepted");
    end
    repeat (4) cyc(1'b0, p, 1'b1, 1'b0, a);

    p = mk(5'd9);
    p.mr = 1'b1;
    p.rw = 1'b1;
    cyc(1'b1, p, 1'b0, 1'b0, a);
    cyc(1'b0, p, 1'b0, 1'b0, a);
    cyc(1'b0, p, 1'b1, 1'b0, a);
    cyc(1'b0, p, 1'b1, 1'b0, a);

    cyc(1'b1, mk(5'd10), 1'b0, 1'b0, a);
    cyc(1'b1, mk(5'd11), 1'b0, 1'b0, a);
    cyc(1'b0, p, 1'b0, 1'b0, a);
    cyc(1'b1, mk(5'd12), 1'b0, 1'b1, a);
    repeat (3) cyc(1'b0, p, 1'b1, 1'b0, a);

    cyc(1'b1, mk(5'd20), 1'b0, 1'b0, a);
    cyc(1'b1, mk(5'd21), 1'b0, 1'b0, a);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_haz_rd", haz_rd, 0);
    chk("async_perf_stall", perf_stall_cnt, 0);
    q.delete();
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), mk(5'($urandom)),
          $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, a);
    end
    repeat (4) cyc(1'b0, p, 1'b1, 1'b0, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
